// File: rtl/norm_shift_pipe.sv
// Pipelined mantissa normaliser: one binary-search shift stage per shamt bit, largest first.
// Elastic valid/ready pipeline with bubble collapse, sync flush and sideband tag pass-through.
module norm_shift_pipe #(
  parameter  int unsigned WIDTH = 24,
  parameter  int unsigned TAGW  = 8,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic             even_mode,
  input  logic [TAGW-1:0]  tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] b,
  output logic [SHW-1:0]   shamt,
  output logic             zero,
  output logic [TAGW-1:0]  tag_out
);

  logic [SHW-1:0]   stg_vld;
  logic [WIDTH-1:0] stg_dat [SHW];
  logic [SHW-1:0]   stg_sha [SHW];
  logic [SHW-1:0]   stg_zro;
  logic [TAGW-1:0]  stg_tag [SHW];
  logic [SHW-2:0]   stg_evn;
  logic [SHW-1:0]   rdy;
  logic             in_fire;

  // A stage can take new data unless it and every stage downstream of it is full and the consumer stalls.
  for (genvar p = 0; p < SHW; p++) begin : g_rdy
    assign rdy[p] = out_ready | ~(&stg_vld[SHW-1:p]);
  end

  assign in_ready = rdy[0] & ~flush;
  assign in_fire  = in_valid & in_ready;

  for (genvar p = 0; p < SHW; p++) begin : g_stage
    localparam int unsigned K  = SHW - 1 - p;
    localparam int unsigned SH = 2 ** K;

    logic             s_vld;
    logic [WIDTH-1:0] s_dat;
    logic [SHW-1:0]   s_sha;
    logic             s_zro;
    logic             s_evn;
    logic [TAGW-1:0]  s_tag;

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] dat_q, dat_d;
    logic [SHW-1:0]   sha_q, sha_d;
    logic             zro_q;
    logic [TAGW-1:0]  tag_q;
    logic             ld;
    logic             do_shift;

    if (p == 0) begin : g_src_in
      assign s_vld = in_fire;
      assign s_dat = a;
      assign s_sha = '0;
      assign s_zro = (a == '0);
      assign s_evn = even_mode;
      assign s_tag = tag_in;
    end else begin : g_src_prev
      assign s_vld = stg_vld[p-1];
      assign s_dat = stg_dat[p-1];
      assign s_sha = stg_sha[p-1];
      assign s_zro = stg_zro[p-1];
      assign s_evn = stg_evn[p-1];
      assign s_tag = stg_tag[p-1];
    end

    assign ld = rdy[p] & s_vld;

    // Shift by 2^K when the top 2^K bits are clear; the 1-bit stage is skipped on the even (sqrt) path.
    always_comb begin
      vld_d    = vld_q;
      dat_d    = dat_q;
      sha_d    = sha_q;
      do_shift = (s_dat[WIDTH-1 -: SH] == '0);
      if (K == 0 && s_evn) do_shift = 1'b0;
      if (flush)       vld_d = 1'b0;
      else if (rdy[p]) vld_d = s_vld;
      if (ld) begin
        dat_d = do_shift ? (s_dat << SH) : s_dat;
        sha_d = s_sha | (do_shift ? SHW'(SH) : '0);
      end
    end

    always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
        vld_q <= 1'b0;
        dat_q <= '0;
        sha_q <= '0;
        zro_q <= 1'b0;
        tag_q <= '0;
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
        sha_q <= sha_d;
        if (ld) begin
          zro_q <= s_zro;
          tag_q <= s_tag;
        end
      end
    end

    // The mode bit is only consumed by the final 1-bit stage, so the last stage does not keep it.
    if (p < SHW - 1) begin : g_evn
      logic evn_q;
      always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)   evn_q <= 1'b0;
        else if (ld) evn_q <= s_evn;
      end
      assign stg_evn[p] = evn_q;
    end

    assign stg_vld[p] = vld_q;
    assign stg_dat[p] = dat_q;
    assign stg_sha[p] = sha_q;
    assign stg_zro[p] = zro_q;
    assign stg_tag[p] = tag_q;
  end

  assign out_valid = stg_vld[SHW-1];
  assign b         = stg_dat[SHW-1];
  assign shamt     = stg_sha[SHW-1];
  assign zero      = stg_zro[SHW-1];
  assign tag_out   = stg_tag[SHW-1];

endmodule

// File: tb/tb_norm_shift_pipe.sv
// Bench for norm_shift_pipe: leading-zero-count reference model with an in-order scoreboard,
// directed corner cases, backpressure, reset/flush scenarios and randomized traffic.
module tb_norm_shift_pipe;
  localparam int unsigned WIDTH = 24;
  localparam int unsigned TAGW  = 8;
  localparam int unsigned SHW   = 5;
  localparam int          DEPTH = 5;

  logic             clk;
  logic             clrn;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic             even_mode;
  logic [TAGW-1:0]  tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic             zero;
  logic [TAGW-1:0]  tag_out;

  norm_shift_pipe #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
    .clk(clk), .clrn(clrn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .even_mode(even_mode), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .b(b), .shamt(shamt), .zero(zero), .tag_out(tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   sh;
    logic             z;
    logic [TAGW-1:0]  tag;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected result from leading-zero count: shift by it (rounded down to even on the sqrt path).
  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic ev, input logic [TAGW-1:0] t);
    exp_t r;
    int   lz;
    int   s;
    lz = 0;
    while (lz < int'(WIDTH) && av[int'(WIDTH) - 1 - lz] == 1'b0) lz++;
    r.tag = t;
    if (av == '0) begin
      r.b  = '0;
      r.sh = ev ? SHW'((1 << SHW) - 2) : SHW'((1 << SHW) - 1);
      r.z  = 1'b1;
    end else begin
      s    = ev ? (lz - (lz % 2)) : lz;
      r.b  = av << s;
      r.sh = SHW'(s);
      r.z  = 1'b0;
    end
    return r;
  endfunction

  // Scoreboard: every result must match the oldest outstanding input, in order.
  always @(negedge clk) begin
    if (!clrn) begin
      q.delete();
    end else begin
      chk("in_ready", 64'(in_ready), 64'(!flush && (q.size() < DEPTH || out_ready)));
      chk("out_valid_without_item", 64'(out_valid && q.size() == 0), 64'(0));
      if (out_valid && q.size() > 0) begin
        chk("b", 64'(b), 64'(q[0].b));
        chk("shamt", 64'(shamt), 64'(q[0].sh));
        chk("zero", 64'(zero), 64'(q[0].z));
        chk("tag_out", 64'(tag_out), 64'(q[0].tag));
      end
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back(model(a, even_mode, tag_in));
      if (flush) q.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [WIDTH-1:0] av, input logic ev,
                         input logic [WIDTH-1:0] eb, input int esh, input logic ez);
    int lat;
    a = av; even_mode = ev; tag_in = 8'($urandom); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", 64'(lat), 64'(SHW - 1));
    chk("dir_b", 64'(b), 64'(eb));
    chk("dir_shamt", 64'(shamt), 64'(esh));
    chk("dir_zero", 64'(zero), 64'(ez));
    tick();
  endtask

  exp_t             m;
  int               acc;
  int               ov_cnt;
  logic             fire;
  logic [WIDTH-1:0] hb;
  logic [TAGW-1:0]  htag;

  initial begin
    clrn = 1'b1; flush = 1'b0; in_valid = 1'b0; a = '0; even_mode = 1'b0; tag_in = '0; out_ready = 1'b1;
    #1 clrn = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_b", 64'(b), 64'(0));
    chk("rst_shamt", 64'(shamt), 64'(0));
    chk("rst_zero", 64'(zero), 64'(0));
    chk("rst_tag_out", 64'(tag_out), 64'(0));
    repeat (2) tick();
    clrn = 1'b1;
    tick();
    chk("in_ready_after_reset", 64'(in_ready), 64'(1));

    m = model(24'h000001, 1'b0, 8'h00);
    chk("model_norm_b", 64'(m.b), 64'h800000);
    chk("model_norm_sh", 64'(m.sh), 64'd23);
    m = model(24'h000001, 1'b1, 8'h00);
    chk("model_even_sh", 64'(m.sh), 64'd22);
    m = model(24'h000000, 1'b1, 8'h00);
    chk("model_zero_even_sh", 64'(m.sh), 64'd30);

    run_one(24'h000001, 1'b0, 24'h800000, 23, 1'b0);
    run_one(24'h000001, 1'b1, 24'h400000, 22, 1'b0);
    run_one(24'h800000, 1'b0, 24'h800000, 0, 1'b0);
    run_one(24'h800000, 1'b1, 24'h800000, 0, 1'b0);
    run_one(24'h000000, 1'b0, 24'h000000, 31, 1'b1);
    run_one(24'h000000, 1'b1, 24'h000000, 30, 1'b1);
    run_one(24'h00F000, 1'b1, 24'hF00000, 8, 1'b0);

    // Backpressure: 7 tagged inputs, consumer stalls from the second cycle.
    acc = 0; out_ready = 1'b1; in_valid = 1'b1; tag_in = 8'd1;
    a = 24'($urandom) | 24'h1; even_mode = 1'($urandom);
    hb = '0; htag = '0;
    for (int c = 0; c < 12; c++) begin
      if (c == 1) out_ready = 1'b0;
      #1;
      fire = in_valid & in_ready;
      if (c == 8) begin hb = b; htag = tag_out; end
      tick();
      if (fire) begin
        acc++;
        tag_in = 8'(acc + 1); a = 24'($urandom) | 24'h1; even_mode = 1'($urandom);
      end
    end
    chk("accepted_while_stalled", 64'(acc), 64'(DEPTH));
    chk("stalled_out_valid", 64'(out_valid), 64'(1));
    chk("held_b", 64'(b), 64'(hb));
    chk("held_tag", 64'(tag_out), 64'(htag));
    out_ready = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      #1;
      chk("drain_valid", 64'(out_valid), 64'(1));
      chk("drain_tag", 64'(tag_out), 64'(t));
      fire = in_valid & in_ready;
      tick();
      if (fire) begin
        acc++;
        if (acc < 7) begin
          tag_in = 8'(acc + 1); a = 24'($urandom) | 24'h1;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    tick();

    // Asynchronous reset with three transactions in flight.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 24'($urandom) | 24'h000100; tag_in = 8'(8'h40 + i); even_mode = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    chk("pre_reset_out_valid", 64'(out_valid), 64'(1));
    #2 clrn = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'(0));
    chk("async_rst_b", 64'(b), 64'(0));
    chk("async_rst_shamt", 64'(shamt), 64'(0));
    chk("async_rst_zero", 64'(zero), 64'(0));
    chk("async_rst_tag", 64'(tag_out), 64'(0));
    tick();
    clrn = 1'b1; out_ready = 1'b1; ov_cnt = 0;
    repeat (10) begin
      tick();
      ov_cnt += int'(out_valid);
    end
    chk("no_results_after_reset", 64'(ov_cnt), 64'(0));

    // Flush with two in flight and a concurrent input.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a = 24'($urandom) | 24'h1; tag_in = 8'(8'h80 + i);
      tick();
    end
    a = 24'h000123; tag_in = 8'hEE; flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'(0));
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_empty", 64'(out_valid), 64'(0));
    ov_cnt = 0;
    repeat (8) begin
      tick();
      ov_cnt += int'(out_valid);
    end
    chk("no_results_after_flush", 64'(ov_cnt), 64'(0));

    // Randomized traffic: mixed modes, leading-zero depths, stalls and occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      a         = 24'($urandom) >> $urandom_range(0, 24);
      even_mode = 1'($urandom);
      tag_in    = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < ((i < 1500) ? 6 : 3));
      flush     = ($urandom_range(0, 63) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (12) tick();
    chk("scoreboard_drained", 64'(q.size()), 64'(0));
    chk("idle_out_valid", 64'(out_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/norm_shift_pipe.md
NORM_SHIFT_PIPE -- requirements
Module: norm_shift_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 24, mantissa width (legal 4..64).
REQ-002 SHALL provide parameter TAGW, default 8, width of sideband tag carried with each transaction.
REQ-003 SHALL derive local SHW = ceil(log2(WIDTH)), default 5, shamt width and pipeline depth.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-005 clrn  in  1  asynchronous active-low reset.
REQ-006 flush  in  1  synchronous pipeline clear, active high.
REQ-007 in_valid  in  1  input transaction present.
REQ-008 in_ready  out  1  block accepts input this cycle.
REQ-009 a  in  WIDTH  unnormalised mantissa.
REQ-010 even_mode  in  1  1 = shift count restricted to even values (sqrt path); 0 = full normalisation.
REQ-011 tag_in  in  TAGW  sideband, passed through unmodified.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  consumer accepts result.
REQ-014 b  out  WIDTH  shifted mantissa.
REQ-015 shamt  out  SHW  total left-shift applied.
REQ-016 zero  out  1  input was all zeros.
REQ-017 tag_out  out  TAGW  tag of the transaction on b.

Function
REQ-018 Transfer on input SHALL occur on a rising edge with in_valid & in_ready; on output with out_valid & out_ready.
REQ-019 Pipeline SHALL have SHW register stages; stage k (k = SHW-1 down to 0, one per stage, largest first) tests top 2^k bits of its operand; if all zero, shift left 2^k and set shamt bit k, else pass unchanged and clear bit k.
REQ-020 In even_mode = 1, stage 0 SHALL never shift; shamt[0] = 0; even_mode travels with its transaction.
REQ-021 In even_mode = 0, result SHALL have b[WIDTH-1] = 1 for any nonzero a.
REQ-022 In even_mode = 1, result SHALL have b[WIDTH-1:WIDTH-2] != 0 for any nonzero a.
REQ-023 Zero input SHALL give b = 0, zero = 1, shamt = 2^SHW-1 (even_mode 0) or 2^SHW-2 (even_mode 1); zero = 0 otherwise.
REQ-024 Stage k SHALL hold its contents when valid and stage k+1 (or output, for last stage) cannot accept; ready_k = ~valid_k | ready_(k+1); last-stage ready = out_ready; in_ready = ready of first stage & ~flush.
REQ-025 Unstalled latency SHALL be SHW cycles: accept on edge E -> out_valid high after edge E+SHW-1; throughput one transaction per cycle.
REQ-026 Capacity SHALL be SHW transactions; order preserved; no drop or duplication under any out_ready pattern.
REQ-027 Bubbles SHALL collapse: an empty stage accepts even when downstream is stalled.
REQ-028 b, shamt, zero, tag_out SHALL be stable while out_valid & ~out_ready.
REQ-029 flush SHALL clear all stage valid bits on the next edge; a concurrent input is not accepted (in_ready = 0); a concurrent output handshake is still counted as completed.

Reset
REQ-030 clrn low SHALL immediately clear all valid bits and stage registers: out_valid = 0, b = 0, shamt = 0, zero = 0, tag_out = 0; in_ready = 1 from the first edge after clrn rises.
REQ-031 Reset mid-operation SHALL discard all in-flight transactions; none appear after release.

Verification (WIDTH=24, SHW=5)
REQ-032 a=0x000001, even_mode=0, out_ready=1 -> b=0x800000, shamt=23, zero=0, out_valid 5 cycles after accept.
REQ-033 a=0x000001, even_mode=1 -> b=0x400000, shamt=22; a=0x800000 either mode -> b=0x800000, shamt=0.
REQ-034 a=0x000000 -> b=0, zero=1, shamt=31 (even_mode 0), shamt=30 (even_mode 1).
REQ-035 7 back-to-back inputs with tags 1..7, out_ready low from cycle 2 -> in_ready drops after 5 held, outputs held stable; on out_ready release tags emerge 1..7 in order, one per cycle.
REQ-036 clrn pulsed low with 3 in flight -> out_valid 0 asynchronously, all outputs 0, no results after release; flush with in_valid=1 and 2 in flight -> in_ready 0, pipeline empty next cycle, input not accepted.
